// File: rtl/regarb_pkg.sv
//------------------------------------------------------------------------------
// regarb_pkg : default sizes and a constant-evaluable clog2 for the arbiter.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regarb_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_N_REG = 8;
  localparam int DEF_DW    = 16;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regbank_wr_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick : combinational round-robin search from a start pointer with wrap.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rr_pick
  import regarb_pkg::*;
#(
  parameter int N  = DEF_N_REQ,
  parameter int PW = clog2(DEF_N_REQ)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  int          k;
  logic [PW-1:0] k_idx;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    k        = 0;
    k_idx    = '0;
    for (int i = 0; i < N; i++) begin
      k     = (int'(ptr_i) + i) % N;
      k_idx = k[PW-1:0];
      if (!valid_o && elig_i[k_idx]) begin
        valid_o         = 1'b1;
        idx_o           = k_idx;
        onehot_o[k_idx] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/regbank_wr_arbiter.sv
//------------------------------------------------------------------------------
// regbank_wr_arbiter : round-robin single-port write arbiter for the register
// bank. Optional REGARB_PRIO0_EN gives requester 0 absolute priority. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regbank_wr_arbiter
  import regarb_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int N_REG = DEF_N_REG,
  parameter  int DW    = DEF_DW,
  localparam int AW    = clog2(N_REG),
  localparam int PW    = clog2(N_REQ)
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REG-1:0]    reg_en,
  output logic [DW-1:0]       reg_wdata,
  output logic                wr_err,
  output logic                busy
);

  logic [N_REQ-1:0] gnt_q,       gnt_d;
  logic [N_REG-1:0] reg_en_q,    reg_en_d;
  logic [DW-1:0]    reg_wdata_q, reg_wdata_d;
  logic             wr_err_q,    wr_err_d;
  logic [PW-1:0]    rr_ptr_q,    rr_ptr_d;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_vld;

  logic [N_REQ-1:0] win_oh;
  logic [PW-1:0]    win_idx;
  logic             win_vld;
  logic             prio_hit;
  logic [AW-1:0]    win_addr;

  // A requester whose grant is still on the outputs is not eligible again.
  assign elig = req & ~gnt_q;

  rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_rr_pick (
    .elig_i   (elig),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_vld)
  );

  always_comb begin
    win_oh   = pick_oh;
    win_idx  = pick_idx;
    win_vld  = pick_vld;
    prio_hit = 1'b0;
`ifdef REGARB_PRIO0_EN
    if (elig[0]) begin
      win_oh   = N_REQ'(1);
      win_idx  = '0;
      win_vld  = 1'b1;
      prio_hit = 1'b1;
    end
`endif
    win_addr = req_addr[win_idx*AW +: AW];

    gnt_d       = '0;
    reg_en_d    = '0;
    wr_err_d    = 1'b0;
    reg_wdata_d = reg_wdata_q;
    rr_ptr_d    = rr_ptr_q;
    if (win_vld) begin
      gnt_d       = win_oh;
      reg_wdata_d = req_data[win_idx*DW +: DW];
      if (int'(win_addr) < N_REG) begin
        reg_en_d = N_REG'(1) << win_addr;
      end else begin
        wr_err_d = 1'b1;
      end
      if (!prio_hit) begin
        rr_ptr_d = (int'(win_idx) == N_REQ - 1) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      gnt_q       <= '0;
      reg_en_q    <= '0;
      reg_wdata_q <= '0;
      wr_err_q    <= 1'b0;
      rr_ptr_q    <= '0;
    end else begin
      gnt_q       <= gnt_d;
      reg_en_q    <= reg_en_d;
      reg_wdata_q <= reg_wdata_d;
      wr_err_q    <= wr_err_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign reg_en    = reg_en_q;
  assign reg_wdata = reg_wdata_q;
  assign wr_err    = wr_err_q;
  assign busy      = |req;

endmodule

`default_nettype wire
